sum_display: RTL and testbench
==============================

# sum_display

Downstream consumer of the 4-bit adder's 5-bit sum (`adds`). It captures a sum on a valid/ready handshake and converts it to two BCD digits with a serial double-dabble FSM. It then drives a two-digit, time-multiplexed, active-low seven-segment display. It is the first clocked stage in the lab top and turns the combinational adder result into a readable decimal value on the board.

## Interface
- `SCAN_CYCLES`, default 50000: clock cycles each digit stays lit. Legal values are ≥ 2.
- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sum_in`  in  5  unsigned sum from the adder, 0..31.
- `sum_valid`  in  1  upstream strobe meaning `sum_in` is ready to capture.
- `sum_ready`  out  1  high when the block can accept a sum (state IDLE).
- `bcd_tens`  out  2  registered tens digit, 0..3.
- `bcd_ones`  out  4  registered ones digit, 0..9.
- `conv_done`  out  1  one-cycle pulse when new digits are committed.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  2  digit enables, active-low, registered. `an[0]` is ones, `an[1]` is tens.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
  - `sum_ready = (state == IDLE)`, decoded combinationally from the state register.
- IDLE:
  - On `sum_valid && sum_ready`, load the shift register with `sum_in`, clear the working BCD registers and the shift counter, and go to SHIFT.
  - If `sum_valid` is low, stay in IDLE.
- SHIFT: runs for exactly 5 cycles, one per input bit, MSB first. Each cycle:
  - If the working ones digit is ≥ 5, add 3 to it. The tens digit never reaches 5, so it is never corrected.
  - Shift {tens, ones, bin} left by 1.
  - After the 5th shift, go to COMMIT.
- COMMIT:
  - Copy the working tens/ones into `bcd_tens`/`bcd_ones`, set `conv_done` = 1, and go to IDLE.
- `sum_valid` outside IDLE is ignored and not queued. Upstream must hold or re-present the sum until it sees `sum_ready` high.
- Width rules: the 5-bit input maps to 2-bit tens and 4-bit ones. Input 31 gives tens=3, ones=1. No saturation is needed.
- Scan counter:
  - Counts 0..SCAN_CYCLES-1, then wraps to 0.
  - `digit_sel` toggles on each wrap.
  - Runs freely and independently of the conversion FSM.
- Display drive, registered every cycle from the committed digits:
  - `digit_sel` = 0: `an` = 2'b10, `seg` = encode(`bcd_ones`).
  - `digit_sel` = 1: if `bcd_tens` = 0, `an` = 2'b11 and `seg` = 7'h7F (leading-zero blanking). Otherwise `an` = 2'b01 and `seg` = encode(`bcd_tens`).
- Segment encoding (active-low, hex of gfedcba):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10

## Timing
- Reset (`rst_n` low, asynchronous):
  - State IDLE, so `sum_ready` = 1.
  - `bcd_tens` = 0, `bcd_ones` = 0, `conv_done` = 0.
  - Scan counter = 0, `digit_sel` = 0.
  - `seg` = 7'h7F, `an` = 2'b11.
- First edge after reset release: `an` = 2'b10, `seg` = 7'h40 (displays "0").
- Conversion timeline, with the handshake accepted at edge k:
  - Edges k+1..k+5: shifts.
  - Edge k+6: COMMIT; the digits update and `conv_done` is high for the cycle after k+6.
  - `sum_ready` is low from after edge k until edge k+6.
  - The earliest next accept is edge k+7, so throughput is 1 sum per 7 cycles.
- Segment outputs reflect new digits on the first display-register update after edge k+6. That means the same edge k+7 for the digit currently selected.
- Reset mid-conversion: abort. Return to IDLE with no `conv_done` pulse and digits cleared to 0.
- If `sum_valid` is held high continuously, a new sum is accepted every 7 cycles, each time using the `sum_in` value present at the accepting edge.
- Scan wrap: `digit_sel` flips at the edge where the counter goes from SCAN_CYCLES-1 to 0. Each digit is lit for exactly SCAN_CYCLES cycles.

## Test plan
- Reset: assert `rst_n` mid-run → all outputs at their reset values immediately, without waiting for a clock edge. Release → `an` = 10 and `seg` = 40 on the next edge.
- Accept 30 (15+15) at edge k → `sum_ready` low for edges k+1..k+6. `conv_done` pulses once after k+6. `bcd_tens` = 3, `bcd_ones` = 0. Tens digit shows `seg` = 30; ones digit shows `seg` = 40.
- Accept 9, with SCAN_CYCLES = 4 → ones shows `seg` = 10. In the tens slot, `an` = 11 and `seg` = 7F (blanked). Each digit slot lasts exactly 4 cycles.
- Accept 31, then pulse `sum_valid` with 17 while busy → 17 is ignored. Final digits are 3 and 1, and `conv_done` pulses only once.
- Hold `sum_valid` high with `sum_in` stepping 0..31 every cycle → accepts land 7 cycles apart. Each commit matches the double-dabble of the value sampled at its accept edge. No `conv_done` pulses are lost.
- Drop `rst_n` at edge k+3 of a conversion of 25 → no `conv_done` pulse. Digits are 0 after release, and the next conversion of 25 gives tens = 2, ones = 5.

Source files
------------

// File: rtl/sum_display.sv
// Captures a 5-bit sum on a valid/ready handshake, converts it to two BCD digits
// with a serial double-dabble FSM, and drives a two-digit multiplexed display.
module sum_display #(
    parameter int SCAN_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] sum_in,
    input  logic       sum_valid,
    output logic       sum_ready,
    output logic [1:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       conv_done,
    output logic [6:0] seg,
    output logic [1:0] an
);
    localparam int CW = (SCAN_CYCLES > 2) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h40;
            4'd1:    seg_encode = 7'h79;
            4'd2:    seg_encode = 7'h24;
            4'd3:    seg_encode = 7'h30;
            4'd4:    seg_encode = 7'h19;
            4'd5:    seg_encode = 7'h12;
            4'd6:    seg_encode = 7'h02;
            4'd7:    seg_encode = 7'h78;
            4'd8:    seg_encode = 7'h00;
            4'd9:    seg_encode = 7'h10;
            default: seg_encode = 7'h7F;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [4:0]      bin_q, bin_d;
    logic [1:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic [3:0]      ones_adj;
    logic [1:0]      bcd_tens_q, bcd_tens_d;
    logic [3:0]      bcd_ones_q, bcd_ones_d;
    logic            conv_done_q, conv_done_d;
    logic [CW-1:0]   scan_q, scan_d;
    logic            digit_sel_q, digit_sel_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;

    assign sum_ready = (state_q == IDLE);
    assign bcd_tens  = bcd_tens_q;
    assign bcd_ones  = bcd_ones_q;
    assign conv_done = conv_done_q;
    assign seg       = seg_q;
    assign an        = an_q;

    // Double-dabble correction only ever applies to the ones digit: tens stays below 5.
    always_comb ones_adj = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        bcd_tens_d  = bcd_tens_q;
        bcd_ones_d  = bcd_ones_q;
        conv_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sum_valid) begin
                    bin_d   = sum_in;
                    tens_d  = 2'd0;
                    ones_d  = 4'd0;
                    cnt_d   = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                tens_d = {tens_q[0], ones_adj[3]};
                ones_d = {ones_adj[2:0], bin_q[4]};
                bin_d  = {bin_q[3:0], 1'b0};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd4) state_d = COMMIT;
            end
            COMMIT: begin
                bcd_tens_d  = tens_q;
                bcd_ones_d  = ones_q;
                conv_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running scan and display drive, decoupled from the conversion FSM.
    always_comb begin
        scan_d      = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        digit_sel_d = (scan_q == SCAN_LAST) ? ~digit_sel_q : digit_sel_q;
        if (!digit_sel_q) begin
            an_d  = 2'b10;
            seg_d = seg_encode(bcd_ones_q);
        end else if (bcd_tens_q == 2'd0) begin
            an_d  = 2'b11;
            seg_d = 7'h7F;
        end else begin
            an_d  = 2'b01;
            seg_d = seg_encode({2'b00, bcd_tens_q});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            bcd_tens_q  <= 2'd0;
            bcd_ones_q  <= 4'd0;
            conv_done_q <= 1'b0;
            scan_q      <= '0;
            digit_sel_q <= 1'b0;
            seg_q       <= 7'h7F;
            an_q        <= 2'b11;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcd_tens_q  <= bcd_tens_d;
            bcd_ones_q  <= bcd_ones_d;
            conv_done_q <= conv_done_d;
            scan_q      <= scan_d;
            digit_sel_q <= digit_sel_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    // Working shift registers are always reloaded on accept, so they carry no reset.
    always_ff @(posedge clk) begin
        bin_q  <= bin_d;
        tens_q <= tens_d;
        ones_q <= ones_d;
    end

endmodule

// File: tb/tb_sum_display.sv
// Directed bench for sum_display with a scoreboard of expected conversions
// and a cycle model of the handshake.
module tb_sum_display;
    localparam int SC = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] sum_in;
    logic       sum_valid;
    logic       sum_ready;
    logic [1:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       conv_done;
    logic [6:0] seg;
    logic [1:0] an;

    sum_display #(.SCAN_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
        .conv_done(conv_done), .seg(seg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] t;
        logic [3:0] o;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   busy   = 0;
    int   n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: model the handshake, push accepts, check ready and due commits.
    task automatic tick();
        logic       acc;
        logic [4:0] v;
        exp_t       e;
        acc = rst_n && sum_valid && (busy == 0);
        v   = sum_in;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n)       busy = 0;
        else if (acc)     busy = 6;
        else if (busy > 0) busy--;
        if (acc) begin
            e.t   = 2'(v / 5'd10);
            e.o   = 4'(v % 5'd10);
            e.due = cyc + 6;
            exp_q.push_back(e);
        end
        chk("sum_ready", 32'(sum_ready), 32'(busy == 0));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("conv_done_pulse", 32'(conv_done), 32'd1);
            chk("bcd_tens", 32'(bcd_tens), 32'(e.t));
            chk("bcd_ones", 32'(bcd_ones), 32'(e.o));
        end else begin
            chk("conv_done_idle", 32'(conv_done), 32'd0);
        end
    endtask

    task automatic wait_an(input logic [1:0] target);
        int k;
        k = 0;
        while (an !== target && k < 50) begin
            tick();
            k++;
        end
        chk("wait_an", 32'(an), 32'(target));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(sum_ready), 32'd1);
        chk({tag, "_tens"},  32'(bcd_tens),  32'd0);
        chk({tag, "_ones"},  32'(bcd_ones),  32'd0);
        chk({tag, "_done"},  32'(conv_done), 32'd0);
        chk({tag, "_seg"},   32'(seg),       32'h7F);
        chk({tag, "_an"},    32'(an),        32'd3);
    endtask

    task automatic send(input logic [4:0] v);
        sum_in    = v;
        sum_valid = 1'b1;
        tick();
        sum_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        sum_valid = 1'b0;
        sum_in    = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        tick();
        chk("first_an", 32'(an), 32'd2);
        chk("first_seg", 32'(seg), 32'h40);

        // 30: tens slot shows 3, ones slot shows 0
        send(5'd30);
        repeat (7) tick();
        chk("d30_tens", 32'(bcd_tens), 32'd3);
        chk("d30_ones", 32'(bcd_ones), 32'd0);
        wait_an(2'b01);
        chk("seg30_tens", 32'(seg), 32'h30);
        wait_an(2'b10);
        chk("seg30_ones", 32'(seg), 32'h40);

        // 9: tens blanked, both slots SC cycles long
        send(5'd9);
        repeat (7) tick();
        wait_an(2'b10);
        chk("seg9_ones", 32'(seg), 32'h10);
        wait_an(2'b11);
        chk("seg9_blank", 32'(seg), 32'h7F);
        n = 0;
        while (an === 2'b11 && n < 20) begin
            n++;
            tick();
        end
        chk("blank_slot_len", 32'(n), 32'(SC));
        n = 0;
        while (an === 2'b10 && n < 20) begin
            n++;
            tick();
        end
        chk("ones_slot_len", 32'(n), 32'(SC));

        // 31 with 17 pulsed while busy
        send(5'd31);
        tick();
        send(5'd17);
        repeat (8) tick();
        chk("d31_tens", 32'(bcd_tens), 32'd3);
        chk("d31_ones", 32'(bcd_ones), 32'd1);

        // Continuous valid with a stepping input
        sum_valid = 1'b1;
        for (int i = 0; i < 43; i++) begin
            sum_in = 5'(i);
            tick();
        end
        sum_valid = 1'b0;
        repeat (8) tick();
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Abort a conversion of 25 with an asynchronous reset
        send(5'd25);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        busy = 0;
        #1;
        check_reset_outputs("async");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rel_an", 32'(an), 32'd2);
        chk("rel_seg", 32'(seg), 32'h40);
        chk("rel_tens", 32'(bcd_tens), 32'd0);
        chk("rel_ones", 32'(bcd_ones), 32'd0);
        send(5'd25);
        repeat (8) tick();
        chk("d25_tens", 32'(bcd_tens), 32'd2);
        chk("d25_ones", 32'(bcd_ones), 32'd5);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
